// File: rtl/fbuf_read_arbiter_pkg.sv
// Shared colour-detect definitions: sampler FSM states, read owner tags,
// and the default frame buffer geometry.
package fbuf_read_arbiter_pkg;

  // 640x480 frame of 16-bit words.
  localparam int FBUF_DEPTH_DEFAULT = 307200;

  // Sampler request tracking.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PEND = 2'd2
  } smp_state_t;

  // Owner of a read travelling down the tag pipe.
  localparam logic TAG_DISP = 1'b0;
  localparam logic TAG_SMP  = 1'b1;

endpackage

// File: rtl/fbuf_read_arbiter_tag_pipe.sv
// Owner tag / valid delay line: carries each issued read alongside the
// frame buffer latency so the return can be steered to its requester.
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic i_p_clk,
  input  logic i_rstn,
  input  logic i_vld,
  input  logic i_tag,
  output logic o_vld,
  output logic o_tag
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] tag_q;

  // Shift the issued-read marker and its owner one stage per cycle.
  always_ff @(posedge i_p_clk) begin
    // NOTE: the delay line is reset (not left as plain storage) because a
    // stale valid bit surviving reset would produce a spurious return.
    if (!i_rstn) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= i_vld;
      tag_q[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign o_vld = vld_q[RD_LAT-1];
  assign o_tag = tag_q[RD_LAT-1];

endmodule

// File: rtl/fbuf_read_arbiter.sv
// Frame buffer read arbiter: the display scan-out always wins; the colour
// sampler is granted one read at a time in display-idle cycles. The frame
// buffer returns i_rdata RD_LAT-1 cycles after the o_ren cycle, and the
// arbiter registers it, so o_*_valid lands RD_LAT cycles after o_ren.
module fbuf_read_arbiter
  import fbuf_read_arbiter_pkg::*;
#(
  parameter int FBUF_DEPTH = FBUF_DEPTH_DEFAULT,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 1024
) (
  input  logic              i_p_clk,
  input  logic              i_rstn,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [15:0]       o_disp_rdata,
  output logic              o_disp_valid,
  input  logic              i_smp_req,
  input  logic [ADDR_W-1:0] i_smp_addr,
  output logic              o_smp_gnt,
  output logic [15:0]       o_smp_rdata,
  output logic              o_smp_valid,
  output logic [ADDR_W-1:0] o_raddr,
  output logic              o_ren,
  input  logic [15:0]       i_rdata,
  output logic              o_addr_err,
  output logic              o_smp_starve
);

  localparam int                CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  LIM     = CNT_W'(STARVE_LIM);
  localparam logic [31:0]       DEPTH_U = 32'(FBUF_DEPTH);

  smp_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              serve_smp;
  logic              smp_blocked;
  logic              issue;
  logic              issue_tag;
  logic              addr_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic              tp_vld;
  logic              tp_tag;

  // Pick this cycle's reader: display first, sampler only with nothing pending.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no
    // latch can be inferred.
    serve_smp   = !i_disp_req && i_smp_req && (state != S_PEND);
    smp_blocked = i_disp_req && i_smp_req && (state != S_PEND);
    issue       = i_disp_req || serve_smp;
    issue_tag   = i_disp_req ? TAG_DISP : TAG_SMP;
    sel_addr    = i_disp_req ? i_disp_addr : i_smp_addr;
    addr_bad    = issue && (32'(sel_addr) >= DEPTH_U);
  end

  // Register the frame buffer read port; out-of-range reads go to word 0.
  always_ff @(posedge i_p_clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!i_rstn) begin
      o_raddr    <= '0;
      o_ren      <= 1'b0;
      o_addr_err <= 1'b0;
    end else begin
      o_ren      <= issue;
      o_addr_err <= addr_bad;
      if (issue) begin
        o_raddr <= addr_bad ? '0 : sel_addr;
      end
    end
  end

  // Sampler FSM with grant pulse, hold-off counter and sticky starvation flag.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      state        <= S_IDLE;
      o_smp_gnt    <= 1'b0;
      wait_cnt     <= '0;
      o_smp_starve <= 1'b0;
    end else begin
      o_smp_gnt <= serve_smp;
      case (state)
        S_IDLE: begin
          if (serve_smp)        state <= S_PEND;
          else if (smp_blocked) state <= S_WAIT;
        end
        S_WAIT: begin
          if (serve_smp)       state <= S_PEND;
          else if (!i_smp_req) state <= S_IDLE;
        end
        S_PEND: begin
          if (o_smp_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Counts cycles the sampler is held off by display; an abandoned
      // request keeps its count, only a grant clears it.
      if (serve_smp) begin
        wait_cnt <= '0;
      end else if (smp_blocked && (wait_cnt != LIM)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (wait_cnt == LIM) begin
        o_smp_starve <= 1'b1;
      end
    end
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .i_p_clk (i_p_clk),
    .i_rstn  (i_rstn),
    .i_vld   (issue),
    .i_tag   (issue_tag),
    .o_vld   (tp_vld),
    .o_tag   (tp_tag)
  );

  // Steer returning data to its owner; rdata holds between valids.
  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      o_disp_valid <= 1'b0;
      o_smp_valid  <= 1'b0;
      o_disp_rdata <= '0;
      o_smp_rdata  <= '0;
    end else begin
      o_disp_valid <= tp_vld && (tp_tag == TAG_DISP);
      o_smp_valid  <= tp_vld && (tp_tag == TAG_SMP);
      if (tp_vld && (tp_tag == TAG_DISP)) o_disp_rdata <= i_rdata;
      if (tp_vld && (tp_tag == TAG_SMP))  o_smp_rdata  <= i_rdata;
    end
  end

endmodule

// File: tb/tb_fbuf_read_arbiter.sv
// Bench for fbuf_read_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share
// the display stimulus, each with its own sampler and frame buffer model.
// A transaction-level reference model predicts all outputs every cycle.
module tb_fbuf_read_arbiter;
  import fbuf_read_arbiter_pkg::*;

  localparam int AW    = 19;
  localparam int DEPTH = 307200;
  localparam int LIM   = 1024;
  localparam int NI    = 2;

  typedef struct packed {
    logic          ren;
    logic [AW-1:0] raddr;
    logic          gnt;
    logic          err;
    logic          dv;
    logic [15:0]   drd;
    logic          sv;
    logic [15:0]   srd;
    logic          starve;
  } outs_t;

  typedef struct {
    int            due;
    logic          owner;
    logic [AW-1:0] addr;
  } ret_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_raddr;
    logic          exp_err;
  } aerr_vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]         disp_req;
  logic [NI-1:0][AW-1:0] disp_addr;
  logic [NI-1:0]         smp_req;
  logic [NI-1:0][AW-1:0] smp_addr;
  logic [NI-1:0][15:0]   disp_rdata;
  logic [NI-1:0]         disp_valid;
  logic [NI-1:0]         smp_gnt;
  logic [NI-1:0][15:0]   smp_rdata;
  logic [NI-1:0]         smp_valid;
  logic [NI-1:0][AW-1:0] raddr;
  logic [NI-1:0]         ren;
  logic [NI-1:0][15:0]   rdata;
  logic [NI-1:0]         addr_err;
  logic [NI-1:0]         smp_starve;

  int n_total = 0;
  int n_bad   = 0;

  // Frame buffer contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd40503) ^ 32'h0000_5a3c;
    return t[15:0];
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : 3;
    logic [AW-1:0] apipe [3];

    fbuf_read_arbiter #(
      .FBUF_DEPTH (DEPTH),
      .ADDR_W     (AW),
      .RD_LAT     (LAT),
      .STARVE_LIM (LIM)
    ) dut (
      .i_p_clk      (clk),
      .i_rstn       (rstn),
      .i_disp_req   (disp_req[k]),
      .i_disp_addr  (disp_addr[k]),
      .o_disp_rdata (disp_rdata[k]),
      .o_disp_valid (disp_valid[k]),
      .i_smp_req    (smp_req[k]),
      .i_smp_addr   (smp_addr[k]),
      .o_smp_gnt    (smp_gnt[k]),
      .o_smp_rdata  (smp_rdata[k]),
      .o_smp_valid  (smp_valid[k]),
      .o_raddr      (raddr[k]),
      .o_ren        (ren[k]),
      .i_rdata      (rdata[k]),
      .o_addr_err   (addr_err[k]),
      .o_smp_starve (smp_starve[k])
    );

    // Frame buffer: data for a read appears LAT-1 cycles after its o_ren cycle.
    always @(posedge clk) begin
      apipe[0] <= raddr[k];
      apipe[1] <= apipe[0];
      apipe[2] <= apipe[1];
    end
    assign rdata[k] = mem_word((LAT == 1) ? raddr[k] : apipe[(LAT > 1) ? LAT - 2 : 0]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int    m_cyc = 0;
  outs_t m_out [NI];
  ret_t  rq [NI][$];
  int    m_free_at [NI];
  int    m_blk [NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // One clock edge of the arbiter as seen from its requesters.
  task automatic model_step(input int k);
    ret_t          r;
    logic [AW-1:0] a;
    logic          bad, dq, sq, serve;
    if (!rstn) begin
      m_out[k]     = '0;
      rq[k].delete();
      m_free_at[k] = 0;
      m_blk[k]     = 0;
      return;
    end
    m_out[k].dv = 1'b0;
    m_out[k].sv = 1'b0;
    while (rq[k].size() > 0 && rq[k][0].due == m_cyc) begin
      r = rq[k].pop_front();
      if (r.owner == TAG_DISP) begin
        m_out[k].dv  = 1'b1;
        m_out[k].drd = mem_word(r.addr);
      end else begin
        m_out[k].sv  = 1'b1;
        m_out[k].srd = mem_word(r.addr);
      end
    end
    if (m_blk[k] >= LIM) m_out[k].starve = 1'b1;
    dq    = disp_req[k];
    sq    = smp_req[k] && (m_cyc >= m_free_at[k]);
    serve = !dq && sq;
    m_out[k].gnt = serve;
    m_out[k].ren = dq || serve;
    m_out[k].err = 1'b0;
    if (dq || serve) begin
      a   = dq ? disp_addr[k] : smp_addr[k];
      bad = (int'(a) >= DEPTH);
      m_out[k].err   = bad;
      m_out[k].raddr = bad ? '0 : a;
      rq[k].push_back('{m_cyc + lat_of(k), dq ? TAG_DISP : TAG_SMP, m_out[k].raddr});
    end
    if (serve) begin
      // pending until the cycle after the sampler's valid cycle
      m_free_at[k] = m_cyc + lat_of(k) + 2;
      m_blk[k]     = 0;
    end else if (dq && sq && m_blk[k] < LIM) begin
      m_blk[k]++;
    end
  endtask

  always @(posedge clk) begin
    m_cyc++;
    for (int k = 0; k < NI; k++) model_step(k);
  end

  // ---------------- checker / monitor ----------------
  logic chk_en = 1'b0;
  int first_dv [NI], n_dv [NI], n_gnt [NI], gnt_cyc [NI], sv_cyc [NI], n_sv [NI];
  logic [AW-1:0] gnt_raddr [NI];

  function automatic outs_t dut_outs(input int k);
    outs_t o;
    o.ren    = ren[k];
    o.raddr  = raddr[k];
    o.gnt    = smp_gnt[k];
    o.err    = addr_err[k];
    o.dv     = disp_valid[k];
    o.drd    = disp_rdata[k];
    o.sv     = smp_valid[k];
    o.srd    = smp_rdata[k];
    o.starve = smp_starve[k];
    return o;
  endfunction

  task automatic clr_mon();
    for (int k = 0; k < NI; k++) begin
      first_dv[k] = -1; n_dv[k] = 0; n_gnt[k] = 0;
      gnt_cyc[k]  = -1; sv_cyc[k] = -1; n_sv[k] = 0; gnt_raddr[k] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("outs_i%0d", k), 64'(dut_outs(k)), 64'(m_out[k]));
        if (disp_valid[k]) begin
          n_dv[k]++;
          if (first_dv[k] < 0) first_dv[k] = m_cyc;
        end
        if (smp_gnt[k]) begin
          n_gnt[k]++;
          gnt_cyc[k]   = m_cyc;
          gnt_raddr[k] = raddr[k];
        end
        if (smp_valid[k]) begin
          n_sv[k]++;
          sv_cyc[k] = m_cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) if (m_out[k].gnt) smp_req[k] = 1'b0;
  endtask

  task automatic set_disp(input logic req, input logic [AW-1:0] a);
    for (int k = 0; k < NI; k++) begin
      disp_req[k]  = req;
      disp_addr[k] = a;
    end
  endtask

  task automatic set_smp(input logic [AW-1:0] a);
    for (int k = 0; k < NI; k++) begin
      smp_req[k]  = 1'b1;
      smp_addr[k] = a;
    end
  endtask

  aerr_vec_t vtab [6];
  int t0;

  initial begin
    vtab[0] = '{19'd307200, 19'd0,     1'b1};
    vtab[1] = '{19'd307199, 19'd307199, 1'b0};
    vtab[2] = '{19'd524287, 19'd0,     1'b1};
    vtab[3] = '{19'd0,      19'd0,     1'b0};
    vtab[4] = '{19'd307201, 19'd0,     1'b1};
    vtab[5] = '{19'd12345,  19'd12345, 1'b0};

    disp_req = '0; disp_addr = '0; smp_req = '0; smp_addr = '0;
    clr_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs_i0", 64'(dut_outs(0)), 64'd0);
    check("reset_outs_i1", 64'(dut_outs(1)), 64'd0);
    chk_en = 1'b1;
    step();
    rstn = 1'b1;
    repeat (2) step();

    // Display scan of one line: 640 consecutive reads, no sampler.
    clr_mon();
    t0 = m_cyc;
    for (int i = 0; i < 640; i++) begin
      set_disp(1'b1, AW'(i));
      step();
    end
    set_disp(1'b0, '0);
    repeat (6) step();
    check("burst_dv_count", 64'(n_dv[0]), 64'd640);
    check("burst_dv_latency", 64'(first_dv[0] - t0), 64'd2);
    check("burst_no_gnt", 64'(n_gnt[0] + n_gnt[1]), 64'd0);

    // Sampler waits on a 20-cycle display burst, granted in first idle cycle.
    clr_mon();
    t0 = m_cyc;
    for (int i = 0; i < 20; i++) begin
      set_disp(1'b1, AW'(100 + i));
      if (i == 5) set_smp(19'd1000);
      step();
    end
    set_disp(1'b0, '0);
    repeat (8) step();
    check("wait_gnt_cycle", 64'(gnt_cyc[0] - t0), 64'd21);
    check("wait_gnt_raddr", 64'(gnt_raddr[0]), 64'd1000);
    check("wait_sv_cycle_lat1", 64'(sv_cyc[0] - t0), 64'd22);
    check("wait_sv_cycle_lat3", 64'(sv_cyc[1] - t0), 64'd24);

    // Display and sampler rise together: display first.
    clr_mon();
    t0 = m_cyc;
    set_smp(19'd2000);
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, AW'(10 + i));
      step();
    end
    set_disp(1'b0, '0);
    repeat (10) step();
    check("simul_dv_lat3", 64'(first_dv[1] - t0), 64'd4);
    check("simul_gnt_lat3", 64'(gnt_cyc[1] - t0), 64'd5);
    check("simul_sv_lat3", 64'(sv_cyc[1] - t0), 64'd8);

    // Address range table.
    for (int i = 0; i < 6; i++) begin
      set_disp(1'b1, vtab[i].addr);
      step();
      @(negedge clk);
      check($sformatf("aerr_raddr_%0d", i), 64'(raddr[0]), 64'(vtab[i].exp_raddr));
      check($sformatf("aerr_pulse_%0d", i), 64'(addr_err[0]), 64'(vtab[i].exp_err));
    end
    set_disp(1'b0, '0);
    step();
    @(negedge clk);
    check("aerr_clear", 64'(addr_err[0]), 64'd0);
    check("idle_raddr_hold", 64'(raddr[0]), 64'd12345);
    check("idle_ren_low", 64'(ren[0]), 64'd0);
    repeat (6) step();

    // Starvation: display busy 1024 cycles with the sampler waiting.
    clr_mon();
    t0 = m_cyc;
    set_smp(19'd777);
    for (int i = 0; i < 1024; i++) begin
      set_disp(1'b1, AW'(i * 3));
      step();
      if (i == 1000) check("starve_early", 64'(smp_starve), 64'd0);
    end
    set_disp(1'b0, '0);
    repeat (4) step();
    check("starve_gnt_cycle", 64'(gnt_cyc[0] - t0), 64'd1025);
    check("starve_set", 64'(smp_starve), 64'(2'b11));
    repeat (50) step();
    check("starve_sticky", 64'(smp_starve), 64'(2'b11));

    // Reset with a sampler read in flight.
    clr_mon();
    t0 = m_cyc;
    set_smp(19'd42);
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("flush_outs_i0", 64'(dut_outs(0)), 64'd0);
    check("flush_outs_i1", 64'(dut_outs(1)), 64'd0);
    check("flush_gnt_seen", 64'(gnt_cyc[1] - t0), 64'd1);
    repeat (8) step();
    check("flush_no_sv", 64'(n_sv[0] + n_sv[1]), 64'd0);
    clr_mon();
    t0 = m_cyc;
    set_smp(19'd43);
    repeat (2) step();
    check("flush_idle_regrant", 64'(gnt_cyc[1] - t0), 64'd1);
    repeat (8) step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 55) begin
        if ($urandom_range(0, 15) == 0)
          set_disp(1'b1, AW'($urandom_range(DEPTH, (1 << AW) - 1)));
        else
          set_disp(1'b1, AW'($urandom_range(0, DEPTH - 1)));
      end else begin
        set_disp(1'b0, disp_addr[0]);
      end
      for (int k = 0; k < NI; k++) begin
        if (!smp_req[k]) begin
          if ($urandom_range(0, 99) < 20) begin
            smp_req[k]  = 1'b1;
            smp_addr[k] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, (1 << AW) - 1))
                                                      : AW'($urandom_range(0, DEPTH - 1));
          end
        end else if ($urandom_range(0, 99) < 3) begin
          smp_req[k] = 1'b0;
        end
      end
      step();
    end
    set_disp(1'b0, '0);
    smp_req = '0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
